icache_responder: RTL and testbench

- Direct-mapped instruction cache.
- Acts as the responder to the datapath's instruction-fetch requests (imemREN/imemaddr), returning imemload qualified by ihit.
- On a miss, acts as initiator toward the memory controller (iREN/iaddr, waits on iwait) and fills one frame.
- Sits between the program counter/fetch stage and the memory arbiter.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/icache_responder_if.sv | 26 ++
 rtl/icache_frame_array.sv | 43 ++++
 rtl/icache_responder.sv | 124 ++++++++++++
 tb/tb_icache_responder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache frame layout and
// cache controller states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int ICACHE_SETS = 16;
   // Widest tag any legal SETS (>= 2) can need.
   localparam int ICACHE_TAG_MAX = 29;

   typedef struct packed {
      logic                      valid;
      logic [ICACHE_TAG_MAX-1:0] tag;
      word_t                     data;
   } icache_frame_t;

   typedef enum logic {
      IDLE,
      FETCH
   } icache_state_t;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache; master is datapath plus memory.
interface icache_responder_if;
   import cpu_types_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  halt;
   logic  ihit;
   word_t imemload;
   logic  iwait;
   word_t iload;
   logic  iREN;
   word_t iaddr;

   modport master (
      output imemREN, imemaddr, halt, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );

   modport slave (
      input  imemREN, imemaddr, halt, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

endinterface

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: one combinational read port, one
// synchronous write port; only valid bits are reset.
module icache_frame_array
   import cpu_types_pkg::*;
#(
   parameter int SETS = ICACHE_SETS,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [IDX_W-1:0] ridx,
   output icache_frame_t    rframe,
   input  logic             wen,
   input  logic [IDX_W-1:0] widx,
   input  icache_frame_t    wframe
);

   logic [SETS-1:0]           valid;
   logic [ICACHE_TAG_MAX-1:0] tags [SETS];
   word_t                     data [SETS];

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         valid <= '0;
      end else if (wen) begin
         valid[widx] <= wframe.valid;
      end
   end

   always_ff @(posedge CLK) begin
      if (wen) begin
         tags[widx] <= wframe.tag;
         data[widx] <= wframe.data;
      end
   end

   always_comb begin
      rframe.valid = valid[ridx];
      rframe.tag   = tags[ridx];
      rframe.data  = data[ridx];
   end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped I-cache: zero-latency hits, blocking single-word fills.
// Define ICACHE_STATS_EN to add saturating hit/miss counter ports.
module icache_responder
   import cpu_types_pkg::*;
#(
   parameter int    SETS    = ICACHE_SETS,
   parameter word_t PC_INIT = '0
) (
   input  logic               CLK,
   input  logic               nRST,
   icache_responder_if.slave  cif
`ifdef ICACHE_STATS_EN
   ,
   output word_t              hit_count,
   output word_t              miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 32 - IDX_W - 2;

   if (SETS < 2 || (SETS & (SETS - 1)) != 0 ||
       PC_INIT[1:0] != 2'b00) begin : g_cfg_err
      $error("icache_responder: bad SETS or PC_INIT");
   end

   icache_state_t    state;
   icache_state_t    next_state;
   word_t            miss_addr;
   logic [IDX_W-1:0] ridx;
   logic [IDX_W-1:0] widx;
   logic [TAG_W-1:0] rtag;
   icache_frame_t    rframe;
   icache_frame_t    wframe;
   logic             hit;
   logic             fill;
   logic             miss_go;
   logic             unused_lsb;

   assign ridx       = cif.imemaddr[IDX_W+1:2];
   assign rtag       = cif.imemaddr[31:IDX_W+2];
   assign widx       = miss_addr[IDX_W+1:2];
   assign unused_lsb = ^cif.imemaddr[1:0];

   assign hit = cif.imemREN & rframe.valid &
                (rframe.tag == ICACHE_TAG_MAX'(rtag));

   assign wframe = '{
      valid: 1'b1,
      tag:   ICACHE_TAG_MAX'(miss_addr[31:IDX_W+2]),
      data:  cif.iload
   };

   icache_frame_array #(.SETS(SETS)) u_frames (
      .CLK    (CLK),
      .nRST   (nRST),
      .ridx   (ridx),
      .rframe (rframe),
      .wen    (fill),
      .widx   (widx),
      .wframe (wframe)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         miss_addr <= '0;
      end else begin
         state <= next_state;
         if (miss_go) begin
            miss_addr <= {cif.imemaddr[31:2], 2'b00};
         end
      end
   end

   // Outputs are forced quiet while nRST is held, even mid-fill.
   always_comb begin
      next_state   = state;
      cif.ihit     = 1'b0;
      cif.imemload = '0;
      cif.iREN     = 1'b0;
      cif.iaddr    = '0;
      miss_go      = 1'b0;
      fill         = 1'b0;
      if (nRST) begin
         unique case (state)
            IDLE: begin
               if (hit) begin
                  cif.ihit     = 1'b1;
                  cif.imemload = rframe.data;
               end else if (cif.imemREN && !cif.halt) begin
                  miss_go    = 1'b1;
                  next_state = FETCH;
               end
            end
            FETCH: begin
               cif.iREN  = 1'b1;
               cif.iaddr = miss_addr;
               if (!cif.iwait) begin
                  fill       = 1'b1;
                  next_state = IDLE;
               end
            end
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (!cif.halt) begin
         if (cif.ihit && hit_count != '1) begin
            hit_count <= hit_count + 32'd1;
         end
         if (miss_go && miss_count != '1) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboarded bench for icache_responder: directed cases then random
// fetches against a line-address model of a direct-mapped cache.
module tb_icache_responder;
   import cpu_types_pkg::*;

   localparam int SETS = 16;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   icache_responder_if bus();

`ifdef ICACHE_STATS_EN
   word_t hit_count;
   word_t miss_count;
`endif

   icache_responder #(.SETS(SETS), .PC_INIT(32'h0)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .cif  (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   typedef struct { word_t data; int lat; } exp_t;
   typedef struct { word_t addr; int cycles; } fill_t;

   exp_t  exp_q[$];
   fill_t fill_q[$];
   word_t mline [int];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    req_start = 0;
   int    cur_wait = 0;
   int    fcnt = 0;
   int    exp_hits = 0;
   int    exp_miss = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic word_t memf(word_t a);
      if (a == 32'h40) return 32'h2001_0005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(string name, word_t act, word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Model: each index remembers the full line address it holds.
   task automatic model_lookup(word_t line, int w, output bit h);
      int idx;
      idx = int'((line >> 2) & word_t'(SETS - 1));
      h = mline.exists(idx) && (mline[idx] == line);
      if (!h) begin
         mline[idx] = line;
         fill_q.push_back('{line, w + 1});
         exp_miss++;
      end
   endtask

   task automatic model_reset();
      mline.delete();
      exp_hits = 0;
      exp_miss = 0;
   endtask

   // Memory: iwait high for cur_wait FETCH cycles, then one data cycle.
   initial begin
      bus.iwait = 1'b1;
      bus.iload = '0;
   end

   always @(posedge CLK) begin
      fill_t f;
      #1;
      if (!bus.iREN) begin
         bus.iwait = 1'b1;
         bus.iload = $urandom;
         fcnt = 0;
      end else if (fcnt < cur_wait) begin
         bus.iwait = 1'b1;
         bus.iload = $urandom;
         fcnt++;
      end else begin
         bus.iwait = 1'b0;
         bus.iload = memf(bus.iaddr);
         if (fill_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fill: iaddr %h", bus.iaddr);
         end else begin
            f = fill_q.pop_front();
            chk("fill_iaddr", bus.iaddr, f.addr);
            chk("fill_iren_cycles", word_t'(fcnt + 1), word_t'(f.cycles));
         end
         fcnt = 0;
      end
   end

   // Monitor: every ihit consumes one expected response.
   always @(negedge CLK) begin
      exp_t e;
      if (bus.ihit) begin
         chk("iren_during_hit", word_t'(bus.iREN), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ihit: imemload %h", bus.imemload);
         end else begin
            e = exp_q.pop_front();
            chk("imemload", bus.imemload, e.data);
            chk("hit_latency", word_t'(cyc - req_start), word_t'(e.lat));
         end
      end else if (nRST) begin
         chk("imemload_zero_no_hit", bus.imemload, 32'd0);
      end
   end

   task automatic wait_hit();
      int n;
      n = 0;
      forever begin
         @(negedge CLK);
         if (bus.ihit) break;
         n++;
         if (n > 64) begin
            checks++;
            errors++;
            $display("FAIL ihit_timeout: got no ihit required ihit");
            break;
         end
      end
   endtask

   task automatic fetch(word_t a, int w);
      bit    h;
      word_t line;
      line = {a[31:2], 2'b00};
      model_lookup(line, w, h);
      if (!bus.halt) exp_hits++;
      exp_q.push_back('{memf(line), h ? 0 : w + 2});
      cur_wait     = w;
      bus.imemREN  = 1'b1;
      bus.imemaddr = a;
      req_start    = cyc;
      wait_hit();
      @(posedge CLK);
      #1;
   endtask

   // Miss on a1, then move to a2 during the fill; a1 is still filled.
   task automatic redirect(word_t a1, word_t a2, int w);
      bit h1;
      bit h2;
      model_lookup(a1, w, h1);
      model_lookup(a2, w, h2);
      exp_hits++;
      exp_q.push_back('{memf(a2), (w + 2) + (h2 ? 0 : w + 2)});
      cur_wait     = w;
      bus.imemREN  = 1'b1;
      bus.imemaddr = a1;
      req_start    = cyc;
      @(posedge CLK);
      #1;
      bus.imemaddr = a2;
      wait_hit();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(int n);
      bus.imemREN  = 1'b0;
      bus.imemaddr = $urandom;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      word_t a;
      bus.imemREN  = 1'b0;
      bus.imemaddr = '0;
      bus.halt     = 1'b0;
      nRST         = 1'b0;
      @(posedge CLK);
      #1;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h40;
      @(negedge CLK);
      chk("reset_ihit", word_t'(bus.ihit), 32'd0);
      chk("reset_iren", word_t'(bus.iREN), 32'd0);
      chk("reset_iaddr", bus.iaddr, 32'd0);
      chk("reset_imemload", bus.imemload, 32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      model_reset();

      fetch(32'h40, 3);
      fetch(32'h40, 0);
      fetch(32'h43, 0);
      fetch(32'h440, 2);
      fetch(32'h40, 1);
      redirect(32'h80, 32'h100, 2);
      fetch(32'h80, 1);
      fetch(32'hFFFF_FFFC, 1);
      fetch(32'h3C, 0);
      fetch(32'hFFFF_FFFC, 2);

      // Halt: cached address still hits, uncached never requests.
      bus.halt = 1'b1;
      fetch(32'hFFFF_FFFC, 0);
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h204;
      repeat (6) begin
         @(negedge CLK);
         chk("halt_no_iren", word_t'(bus.iREN), 32'd0);
         chk("halt_no_ihit", word_t'(bus.ihit), 32'd0);
         @(posedge CLK);
         #1;
      end
      bus.halt = 1'b0;
      fetch(32'h204, 1);

      // Reset while a fill is outstanding.
      fetch(32'h8, 1);
      fetch(32'h8, 0);
      cur_wait     = 6;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h30C;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("fetch_iren", word_t'(bus.iREN), 32'd1);
      chk("fetch_iaddr", bus.iaddr, 32'h30C);
      @(posedge CLK);
      #1;
      nRST        = 1'b0;
      bus.imemREN = 1'b0;
      @(negedge CLK);
      chk("in_reset_iren", word_t'(bus.iREN), 32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      model_reset();
      @(negedge CLK);
      chk("post_reset_iren", word_t'(bus.iREN), 32'd0);
      @(posedge CLK);
      #1;
      fetch(32'h8, 2);

      for (int i = 0; i < 400; i++) begin
         int ts;
         ts = $urandom_range(0, 3);
         a = (word_t'($urandom_range(0, 15)) << 2) |
             word_t'($urandom_range(0, 3));
         if (ts == 3) a = a | 32'hFFFF_FFC0;
         else a = a | (word_t'(ts) << 6);
         fetch(a, $urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(2);

`ifdef ICACHE_STATS_EN
      @(negedge CLK);
      chk("hit_count", hit_count, word_t'(exp_hits));
      chk("miss_count", miss_count, word_t'(exp_miss));
`endif
      chk("exp_q_drained", word_t'(exp_q.size()), 32'd0);
      chk("fill_q_drained", word_t'(fill_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
